// File: rtl/wb_port_arbiter_if.sv
// Writeback-port arbitration bus: per-source requests/addresses in, registered grant and
// regfile write controls out.
interface wb_port_arbiter_if;
  logic [4:0]  req;
  logic [24:0] waddr_bus;
  logic        flush;
  logic [4:0]  gnt;
  logic [2:0]  m5reg;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic        busy;

  modport master (
    output req, waddr_bus, flush,
    input  gnt, m5reg, rf_we, rf_waddr, busy
  );

  modport slave (
    input  req, waddr_bus, flush,
    output gnt, m5reg, rf_we, rf_waddr, busy
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Single register-file write port arbiter for five writeback sources. Source 4 (CP0/exc) always
// wins; sources 0-3 share by round-robin (RR_EN=1) or fixed order 1,2,0,3 (RR_EN=0).
module wb_port_arbiter #(
  parameter int unsigned RR_EN = 1
) (
  input logic              clk,
  input logic              rst,
  wb_port_arbiter_if.slave bus
);

  logic [4:0] gnt_q, gnt_d;
  logic [2:0] m5reg_q, m5reg_d;
  logic       rf_we_q, rf_we_d;
  logic [4:0] rf_waddr_q, rf_waddr_d;
  logic [1:0] ptr_q, ptr_d;

  logic [4:0] elig;
  logic [3:0] rot;
  logic [1:0] rr_off;
  logic [1:0] rr_idx;
  logic       rr_hit;
  logic [1:0] fp_idx;
  logic       fp_hit;
  logic       win_valid;
  logic [2:0] win_idx;
  logic [4:0] win_waddr;

  // The source being granted this cycle is completing, so it cannot win again yet.
  always_comb begin
    elig = bus.req & ~gnt_q;
    if (bus.flush) begin
      elig[3:0] = 4'b0000;
    end
  end

  // Rotate so the pointer position sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    rot    = 4'({elig[3:0], elig[3:0]} >> ptr_q);
    rr_hit = |rot;
    rr_off = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rot[i]) begin
        rr_off = 2'(i);
      end
    end
    rr_idx = ptr_q + rr_off;
  end

  always_comb begin
    fp_hit = 1'b1;
    fp_idx = 2'd0;
    if (elig[1]) begin
      fp_idx = 2'd1;
    end else if (elig[2]) begin
      fp_idx = 2'd2;
    end else if (elig[0]) begin
      fp_idx = 2'd0;
    end else if (elig[3]) begin
      fp_idx = 2'd3;
    end else begin
      fp_hit = 1'b0;
    end
  end

  always_comb begin
    win_valid = 1'b1;
    win_idx   = 3'd4;
    if (!elig[4]) begin
      if (RR_EN != 0) begin
        win_valid = rr_hit;
        win_idx   = {1'b0, rr_idx};
      end else begin
        win_valid = fp_hit;
        win_idx   = {1'b0, fp_idx};
      end
    end
  end

  always_comb begin
    unique case (win_idx)
      3'd0:    win_waddr = bus.waddr_bus[4:0];
      3'd1:    win_waddr = bus.waddr_bus[9:5];
      3'd2:    win_waddr = bus.waddr_bus[14:10];
      3'd3:    win_waddr = bus.waddr_bus[19:15];
      default: win_waddr = bus.waddr_bus[24:20];
    endcase
  end

  // Idle cycles drop the write enable but keep the last select/address on the mux.
  always_comb begin
    gnt_d      = 5'b00000;
    rf_we_d    = 1'b0;
    m5reg_d    = m5reg_q;
    rf_waddr_d = rf_waddr_q;
    ptr_d      = ptr_q;
    if (win_valid) begin
      gnt_d      = 5'b00001 << win_idx;
      m5reg_d    = win_idx;
      rf_waddr_d = win_waddr;
      rf_we_d    = |win_waddr;
      if ((RR_EN != 0) && !win_idx[2]) begin
        ptr_d = win_idx[1:0] + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q      <= 5'b00000;
      m5reg_q    <= 3'b000;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      ptr_q      <= 2'd0;
    end else begin
      gnt_q      <= gnt_d;
      m5reg_q    <= m5reg_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      ptr_q      <= ptr_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.m5reg    = m5reg_q;
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.busy     = |(bus.req & ~gnt_q);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: one round-robin and one fixed-priority instance share stimulus and
// are checked every cycle against a priority-list model, plus directed literal expectations.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [24:0] waddr_bus;
  logic [4:0]  req_rr, req_fp;
  logic [4:0]  hold;
  logic [4:0]  lg_rr, lg_fp;
  int          n_chk, n_pass;

  localparam logic [24:0] WaddrDef = {5'd14, 5'd11, 5'd10, 5'd9, 5'd8};

  wb_port_arbiter_if if_rr ();
  wb_port_arbiter_if if_fp ();

  assign if_rr.req       = req_rr;
  assign if_rr.flush     = flush;
  assign if_rr.waddr_bus = waddr_bus;
  assign if_fp.req       = req_fp;
  assign if_fp.flush     = flush;
  assign if_fp.waddr_bus = waddr_bus;

  wb_port_arbiter #(.RR_EN(1)) u_rr (.clk(clk), .rst(rst), .bus(if_rr));
  wb_port_arbiter #(.RR_EN(0)) u_fp (.clk(clk), .rst(rst), .bus(if_fp));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
  endtask

  // Model: source 4 first, then the 0-3 sources in the order the policy dictates.
  int fixed_ord [4] = '{1, 2, 0, 3};

  function automatic int pick(input logic [4:0] e, input int p, input bit rr);
    int ord [4];
    if (e[4]) return 4;
    for (int k = 0; k < 4; k++) ord[k] = rr ? (p + k) % 4 : fixed_ord[k];
    for (int k = 0; k < 4; k++) if (e[ord[k]]) return ord[k];
    return -1;
  endfunction

  logic [4:0] mg [2];
  logic [2:0] mm [2];
  logic       mw [2];
  logic [4:0] ma [2];
  int         mp [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        mg[d] <= '0; mm[d] <= '0; mw[d] <= 1'b0; ma[d] <= '0; mp[d] <= 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin : mdl
        logic [4:0] e;
        logic [4:0] wa;
        int         w;
        e = ((d == 0) ? req_rr : req_fp) & ~mg[d];
        if (flush) e[3:0] = 4'b0000;
        w = pick(e, mp[d], d == 0);
        if (w < 0) begin
          mg[d] <= '0;
          mw[d] <= 1'b0;
        end else begin
          wa = waddr_bus[5*w +: 5];
          mg[d] <= 5'b00001 << w;
          mm[d] <= 3'(w);
          ma[d] <= wa;
          mw[d] <= (wa != 5'd0);
          if (d == 0 && w < 4) mp[d] <= (w + 1) % 4;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("rr.gnt", if_rr.gnt, mg[0]);
    chk("rr.m5reg", if_rr.m5reg, mm[0]);
    chk("rr.rf_we", if_rr.rf_we, mw[0]);
    chk("rr.rf_waddr", if_rr.rf_waddr, ma[0]);
    chk("rr.busy", if_rr.busy, |(req_rr & ~mg[0]));
    chk("fp.gnt", if_fp.gnt, mg[1]);
    chk("fp.m5reg", if_fp.m5reg, mm[1]);
    chk("fp.rf_we", if_fp.rf_we, mw[1]);
    chk("fp.rf_waddr", if_fp.rf_waddr, ma[1]);
    chk("fp.busy", if_fp.busy, |(req_fp & ~mg[1]));
  end

  always @(negedge clk) begin
    lg_rr <= if_rr.gnt;
    lg_fp <= if_fp.gnt;
  end

  // Requesters drop req the cycle after their grant unless marked as re-requesting.
  task automatic tick();
    @(posedge clk);
    #1;
    req_rr = req_rr & ~(lg_rr & ~hold);
    req_fp = req_fp & ~(lg_fp & ~hold);
  endtask

  task automatic drive(input logic [4:0] r, input logic [4:0] h);
    req_rr = r;
    req_fp = r;
    hold   = h;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    drive(5'b00000, 5'b00000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int rr_ord [5] = '{0, 1, 2, 3, 0};

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    flush = 1'b0;
    waddr_bus = WaddrDef;
    drive(5'b00000, 5'b00000);
    #3;
    chk("reset_gnt", if_rr.gnt, 0);
    chk("reset_we", if_rr.rf_we, 0);
    chk("reset_m5reg", if_rr.m5reg, 0);
    chk("reset_waddr", if_rr.rf_waddr, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single ALU write
    tick();
    drive(5'b00001, 5'b00000);
    tick();
    @(negedge clk);
    chk("alu_gnt", if_rr.gnt, 5'b00001);
    chk("alu_m5reg", if_rr.m5reg, 0);
    chk("alu_we", if_rr.rf_we, 1);
    chk("alu_waddr", if_rr.rf_waddr, 8);
    tick();
    @(negedge clk);
    chk("alu_we_drop", if_rr.rf_we, 0);
    chk("alu_gnt_drop", if_rr.gnt, 0);
    chk("alu_waddr_hold", if_rr.rf_waddr, 8);

    // Round-robin with four sources held
    do_reset();
    tick();
    drive(5'b01111, 5'b01111);
    for (int k = 0; k < 5; k++) begin
      tick();
      @(negedge clk);
      chk("rr_order_m5reg", if_rr.m5reg, rr_ord[k]);
      chk("rr_order_gnt", if_rr.gnt, 5'b00001 << rr_ord[k]);
    end
    drive(5'b00000, 5'b00000);

    // Source 4 overtakes pending 1 and 2
    do_reset();
    tick();
    drive(5'b10110, 5'b00000);
    tick();
    @(negedge clk);
    chk("cp0_gnt", if_rr.gnt, 5'b10000);
    chk("cp0_m5reg", if_rr.m5reg, 4);
    chk("cp0_waddr", if_rr.rf_waddr, 14);
    chk("cp0_we", if_rr.rf_we, 1);
    tick();
    @(negedge clk);
    chk("after_cp0_gnt", if_rr.gnt, 5'b00010);
    chk("after_cp0_waddr", if_rr.rf_waddr, 9);
    tick();
    @(negedge clk);
    chk("after_cp0_gnt2", if_rr.gnt, 5'b00100);
    tick();
    @(negedge clk);
    chk("cp0_idle", if_rr.gnt, 0);

    // Flush blocks 0-3 for three cycles; source 4 still granted
    do_reset();
    tick();
    flush = 1'b1;
    drive(5'b11110, 5'b00000);
    tick();
    @(negedge clk);
    chk("flush_cp0_gnt", if_rr.gnt, 5'b10000);
    tick();
    @(negedge clk);
    chk("flush_gnt0", if_rr.gnt, 0);
    chk("flush_we0", if_rr.rf_we, 0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_gnt1", if_rr.gnt, 0);
    chk("flush_we1", if_rr.rf_we, 0);
    tick();
    @(negedge clk);
    chk("flush_resume", if_rr.gnt, 5'b00010);
    tick();
    @(negedge clk);
    chk("flush_resume2", if_rr.gnt, 5'b00100);
    drive(5'b00000, 5'b00000);

    // Write to $0 retires without enabling the regfile
    do_reset();
    waddr_bus[19:15] = 5'd0;
    tick();
    drive(5'b01000, 5'b00000);
    tick();
    @(negedge clk);
    chk("r0_gnt", if_rr.gnt, 5'b01000);
    chk("r0_m5reg", if_rr.m5reg, 3);
    chk("r0_we", if_rr.rf_we, 0);
    tick();
    @(negedge clk);
    chk("r0_retired", if_rr.busy, 0);
    waddr_bus = WaddrDef;

    // Asynchronous reset mid-write, then fixed-priority order
    do_reset();
    tick();
    drive(5'b00100, 5'b00000);
    tick();
    @(negedge clk);
    chk("pre_rst_gnt", if_rr.gnt, 5'b00100);
    #2;
    rst = 1'b1;
    #1;
    chk("async_gnt", if_rr.gnt, 0);
    chk("async_we", if_rr.rf_we, 0);
    chk("async_m5reg", if_rr.m5reg, 0);
    chk("async_waddr", if_rr.rf_waddr, 0);
    chk("async_fp_gnt", if_fp.gnt, 0);
    @(negedge clk);
    drive(5'b01101, 5'b00000);
    @(negedge clk);
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("fp_first", if_fp.m5reg, 2);
    tick();
    @(negedge clk);
    chk("fp_second", if_fp.gnt, 5'b00001);
    tick();
    @(negedge clk);
    chk("fp_third", if_fp.gnt, 5'b01000);
    chk("fp_third_m5reg", if_fp.m5reg, 3);
    drive(5'b00000, 5'b00000);
    tick();
    tick();
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbitrates the single register-file write port between the five writeback sources: ALU result, memory load data, link address, HI/LO and CP0/exception address. Each cycle it picks at most one pending source and drives the writeback mux select (`m5reg`), the register-file write enable and the destination address, all registered. Requesters handshake with a req/grant pair and hold their data until granted. It sits between the execute/memory/CP0 units and the writeback mux feeding the regfile.

## Interface
Parameters:
- `RR_EN`, default 1: 1 = round-robin among sources 0–3; 0 = fixed priority 1 > 2 > 0 > 3.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  5  write request per source, index = mux code (0 ALU, 1 DMEM, 2 link/NPC, 3 HI/LO, 4 CP0/exc).
- `waddr_bus`  in  25  destination register per source, `waddr_bus[5i+4:5i]` belongs to source i.
- `flush`  in  1  while high, sources 0–3 are not granted. Source 4 is unaffected.
- `gnt`  out  5  one-hot grant, registered; high in the write cycle.
- `m5reg`  out  3  writeback mux select, registered, equals index of granted source.
- `rf_we`  out  1  register-file write enable, registered.
- `rf_waddr`  out  5  register-file write address, registered.
- `busy`  out  1  combinational: some `req` bit is high and not currently granted.

## Operation
- Eligible set E = `req` & ~`gnt` (the source granted this cycle is masked; it is completing), with bits 0–3 also masked when `flush`=1.
- Source 4 has absolute priority: if E[4], it wins.
- Otherwise, with RR_EN=1, the winner is the first set bit of E[3:0] scanning upward from pointer `ptr` (2 bits) with wrap 3→0. With RR_EN=0 the winner follows fixed order 1,2,0,3.
- On a winner w at clock edge: `gnt`<=onehot(w), `m5reg`<=w, `rf_waddr`<=`waddr_bus[5w+4:5w]`, `rf_we`<=(waddr≠0). If w<4 and RR_EN=1, then `ptr`<=(w+1) mod 4. A grant to source 4 leaves `ptr` unchanged.
- With no winner: `gnt`<=0, `rf_we`<=0, and `m5reg`/`rf_waddr` hold their last values.
- Register $0 write: a grant is still issued so the requester retires, but `rf_we`=0.
- Requester rules: assert `req` with stable waddr and data. Hold both through the cycle in which its `gnt` bit is high. Drop `req` in the following cycle, or keep it high for a new write. A requester that keeps `req` high can be granted again at the earliest two cycles later.
- A `req` bit that drops before it is granted is legal. That request is discarded with no side effect.
- Reset (asynchronous, any time): `gnt`=0, `rf_we`=0, `m5reg`=3'b000, `rf_waddr`=0, `ptr`=0. Any write in flight is abandoned, and no partial write occurs after `rst` is deasserted.

## Timing
- Latency: `req` seen high in cycle t → `gnt`, `m5reg`, `rf_we`, `rf_waddr` valid in cycle t+1. The regfile writes on the rising edge that ends cycle t+1.
- Throughput: one write per cycle when at least two sources are pending.
- `flush` is sampled at the same edge as `req`. If `flush` is high in cycle t, no grant to sources 0–3 appears in t+1.
- Simultaneous requests: the loser stays pending and its `busy` contribution remains. Under RR_EN=1, worst-case wait for sources 0–3 is 4 cycles plus any source-4 cycles.
- `busy` is combinational from `req` and `gnt`, with no internal state besides `ptr`.

## Test plan
- Reset then single ALU request (req=5'b00001, waddr0=5'd8): cycle t+1 shows gnt=00001, m5reg=000, rf_we=1, rf_waddr=8; cycle t+2 shows rf_we=0 after req drops.
- All four of sources 0–3 held continuously with RR_EN=1 from ptr=0: grant order 0,1,2,3,0,… Each source is granted no more often than every second cycle, and m5reg matches each grant.
- Source 4 (waddr=5'd14) rises while sources 1 and 2 are pending: source 4 is granted next (m5reg=100). `ptr` is unchanged, so the next grant goes to the round-robin winner it would have been before.
- `flush`=1 for 3 cycles with req=5'b01110 pending: gnt=0 and rf_we=0 throughout. When `flush` falls, grants resume, and a simultaneous source-4 request is still granted during the flush.
- Write to $0 (source 3, waddr=0): gnt[3]=1, m5reg=011, rf_we=0. The requester retires normally.
- Assert `rst` in the cycle after a grant: outputs go to their reset values immediately without waiting for `clk`. With RR_EN=0 and req=5'b01101, the post-reset grant order is 2, 0, 3.
